// File: rtl/garage_data_mem.sv
// Hack CPU data memory: synchronous RAM with a post-reset clear sequencer and an MMIO window (SW/LED/CNT).
// Optional sticky out-of-range trap on port oor, enabled by defining GARAGE_DATA_MEM_OOR_TRAP_EN.
module garage_data_mem #(
  parameter int DATA_WIDTH         = 16,
  parameter int ADDR_WIDTH         = 15,
  parameter int RAM_REGISTER_COUNT = 1024,
  parameter int MMIO_BASE          = 24576,
  parameter int SW_WIDTH           = 10,
  parameter int LED_WIDTH          = 10
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  input  logic [SW_WIDTH-1:0]   sw,
  output logic [LED_WIDTH-1:0]  led
`ifdef GARAGE_DATA_MEM_OOR_TRAP_EN
  ,
  output logic                  oor
`endif
);

  localparam int RAM_AW = $clog2(RAM_REGISTER_COUNT);
  localparam logic [ADDR_WIDTH-1:0] RAM_LIMIT = ADDR_WIDTH'(RAM_REGISTER_COUNT);
  localparam logic [ADDR_WIDTH-1:0] SW_ADDR   = ADDR_WIDTH'(MMIO_BASE);
  localparam logic [ADDR_WIDTH-1:0] LED_ADDR  = ADDR_WIDTH'(MMIO_BASE + 1);
  localparam logic [ADDR_WIDTH-1:0] CNT_ADDR  = ADDR_WIDTH'(MMIO_BASE + 2);
  localparam logic [RAM_AW-1:0]     CLR_LAST  = RAM_AW'(RAM_REGISTER_COUNT - 1);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e                state_q;
  logic [RAM_AW-1:0]     clr_ptr_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] cnt_d;
  logic [LED_WIDTH-1:0]  led_q;
  logic [DATA_WIDTH-1:0] mem [RAM_REGISTER_COUNT];

  logic                  run;
  logic                  in_ram;
  logic                  hit_sw;
  logic                  hit_led;
  logic                  hit_cnt;
  logic [RAM_AW-1:0]     ram_idx;
  logic                  ram_we;
  logic [RAM_AW-1:0]     ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] mmio_rd;

  assign run     = (state_q == RUN);
  assign in_ram  = (addr < RAM_LIMIT);
  assign hit_sw  = (addr == SW_ADDR);
  assign hit_led = (addr == LED_ADDR);
  assign hit_cnt = (addr == CNT_ADDR);
  assign ram_idx = addr[RAM_AW-1:0];

  // The clear sequencer owns the single RAM write port until RUN.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = ram_idx;
    ram_wdata = wdata;
    if (!Reset) begin
      if (!run) begin
        ram_we    = 1'b1;
        ram_waddr = clr_ptr_q;
        ram_wdata = '0;
      end else if (we && in_ram) begin
        ram_we = 1'b1;
      end
    end
  end

  always_comb begin
    mmio_rd = '0;
    if (hit_sw)       mmio_rd = DATA_WIDTH'(sw);
    else if (hit_led) mmio_rd = DATA_WIDTH'(led_q);
    else if (hit_cnt) mmio_rd = cnt_q;
  end

  assign cnt_d = (we && hit_cnt) ? wdata : cnt_q + 1'b1;

  always_ff @(posedge Clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
    end else if (state_q == CLEAR) begin
      clr_ptr_q <= clr_ptr_q + 1'b1;
      if (clr_ptr_q == CLR_LAST) begin
        state_q <= RUN;
        busy_q  <= 1'b0;
      end
    end
  end

  // Reads sample the old contents, giving read-before-write on every target.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rdata_q <= '0;
      led_q   <= '0;
      cnt_q   <= '0;
    end else if (run) begin
      rdata_q <= in_ram ? mem[ram_idx] : mmio_rd;
      if (we && hit_led) led_q <= wdata[LED_WIDTH-1:0];
      cnt_q <= cnt_d;
    end else begin
      rdata_q <= '0;
    end
  end

`ifdef GARAGE_DATA_MEM_OOR_TRAP_EN
  logic oor_q;
  logic unmapped;

  assign unmapped = !(in_ram || hit_sw || hit_led || hit_cnt);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      oor_q <= 1'b0;
    end else if (run && (unmapped || (we && hit_sw))) begin
      oor_q <= 1'b1;
    end
  end

  assign oor = oor_q;
`endif

  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign led   = led_q;

endmodule
